mem_arb: RTL and testbench
==========================

# mem_arb

Memory-port arbiter between the instruction cache and the data cache. It shares the CPU's single external memory bus among three requesters: I-cache line fill, D-cache line fill/uncached load, and D-cache store/writeback. Requesters are served one transfer at a time. A fixed priority applies, with a starvation guard for the I-side. The arbiter latches the address and length of each transfer, and it reports per-beat data, completion and bus errors back to the winning requester.

## Interface
- BEATS, 4: beats per cache-line burst (64-bit beats); power of two, 2..16.
- TMO, 255: cycles without `memack` before a transfer is aborted as a bus error.
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- icreq  in  1  I-side line fill request; held until `icdone`.
- icaddr  in  32  I-side physical address.
- icgnt  out  1  I-side owns bus (XFER and DONE states).
- icvalid  out  1  beat of read data on `memrdata` valid for I-side.
- icdone  out  1  one-cycle completion pulse.
- icerr  out  1  with `icdone`: transfer ended in bus error or timeout.
- dcreq  in  1  D-side request; held until `dcdone`.
- dcwe  in  1  D-side write (1) or read (0); sampled with `dcreq`.
- dcburst  in  1  full-line burst (1) or single beat (0).
- dcaddr  in  32  D-side physical address.
- dcsz  in  3  single-beat size (0=byte, 1=half, 3=word, 7=dword); ignored for bursts.
- dcwdata  in  64  write data for the current beat.
- dcgnt, dcvalid, dcdone, dcerr  out  1 each  as for I-side.
- dcwack  out  1  current write beat accepted; requester presents next beat next cycle.
- memreq  out  1  bus transfer active.
- memwe  out  1  write transfer.
- memaddr  out  32  transfer address; stable for the whole transfer.
- memsz  out  3  beat size (7 for bursts).
- memlen  out  4  beats minus one.
- memwdata  out  64  `dcwdata` passed through while a D-write is granted, else 0.
- memack  in  1  beat completed this cycle.
- memrdata  in  64  read beat, valid with `memack`; routed to both requesters, qualified by the valid signals.
- memerr  in  1  bus error; terminates the transfer.

## Operation
- States: IDLE, XFER, DONE.
- **IDLE:** if any request is present, select a winner and enter XFER at the next edge.
- **Latching on entry to XFER:** owner, `memwe`, `memsz`, `memlen`, and `memaddr` are latched.
  - Burst transfers: `memaddr` has its low log2(BEATS*8) bits cleared, `memsz`=7, and `memlen`=BEATS-1.
  - I-side transfers are always bursts.
  - Single D-beat transfers: `memaddr` is `dcaddr` unchanged, and `memlen`=0.
- **Priority:** D-write > D-read > I-read. The starvation counter `dstreak` (2 bits) overrides this:
  - `dstreak` increments on each D grant made while `icreq` is high.
  - At 2, the next grant goes to the I-side if `icreq` is high.
  - `dstreak` clears on any I grant.
- **XFER:**
  - `memreq`=1.
  - Each `memack` increments the beat counter and pulses the owner's `icvalid`/`dcvalid` (read) or `dcwack` (write).
  - Exit to DONE on `memack` of beat `memlen`, on `memerr`, or when the timeout counter reaches TMO.
  - The timeout counter clears on every `memack`.
- **DONE:** one cycle.
  - `memreq`=0.
  - The owner's done pulse is asserted, with err set if the exit was caused by `memerr` or timeout.
  - Next state is IDLE.
- **Requester obligations:** a requester must hold its request until done. If `req` drops mid-transfer, the transfer still completes and the done pulse is still issued; the arbiter does not cancel.
- A request arriving while another transfer is in flight waits; it is evaluated in IDLE.
- `memack` and `memerr` in the same cycle: the beat is counted and a valid pulse is issued, but err wins and the transfer terminates.
- `memack` outside XFER is ignored.

## Timing
- Request to `memreq`/grant: 1 cycle (request sampled in IDLE at edge N; grant and `memreq` high after edge N).
- Done pulse: the cycle after the final `memack`. Grants drop at the end of DONE.
- Back-to-back transfers: minimum 1 IDLE cycle between DONE and the next XFER, so `memreq` is low for at least 2 cycles between transfers.
- Valid/wack are combinational from `memack` in XFER (same cycle).
- **Reset (asynchronous, any state):**
  - State goes to IDLE, and all counters and `dstreak` go to 0.
  - Every output goes to 0: `memreq`, `memwe`, `memaddr`, `memsz`, `memlen`, `memwdata`, all grant, valid, done, err and wack signals.
  - An in-flight transfer is abandoned with no done pulse.
- Release of `reset_n` takes effect at the next rising edge.

## Test plan
- **I-side burst:** `icreq`, `icaddr`=0x1234 -> `memaddr`=0x1220, `memlen`=3. `memack` for 4 cycles gives 4 `icvalid` pulses, then `icdone`=1 with `icerr`=0 in the following cycle.
- **Simultaneous requests:** `dcreq`+`dcwe` (single, `dcsz`=3, `dcaddr`=0x100) and `icreq` asserted together -> D-write first: `memwe`=1, `memsz`=3, `memlen`=0, one `dcwack`. The I-burst is granted after DONE plus 1 IDLE cycle.
- **Starvation:** `icreq` held while D-side issues 3 consecutive reads -> order is D, D, I, D; `dstreak` clears after the I grant.
- **Bus error:** `memerr` on beat 2 of a D-read burst -> `dcdone`=1 with `dcerr`=1 the next cycle; no further `dcvalid`.
- **Timeout:** no `memack` for TMO=255 cycles in XFER -> `icdone`=1 with `icerr`=1. Timer restart is checked by a single `memack` at cycle 200, after which the abort occurs 255 cycles later.
- **Reset mid-burst:** `reset_n` low during beat 1 -> all outputs 0 asynchronously and no done pulse. After release, a fresh `icreq` is granted normally with beat count starting at 0.

Source files
------------

// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb
//
// Shares the single external memory bus between three requesters: I-cache
// line fill, D-cache line fill / uncached load, and D-cache store/writeback.
// One transfer is in flight at a time. D-side wins over I-side, except that a
// 2-bit streak counter forces an I grant after two D grants that were made
// while the I-side was waiting.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   icreq, icaddr          I-side line-fill request and address
//   icgnt/icvalid/icdone/icerr   I-side grant, read-beat strobe, done, error
//   dcreq, dcwe, dcburst, dcaddr, dcsz, dcwdata   D-side request and payload
//   dcgnt/dcvalid/dcdone/dcerr/dcwack   D-side grant, read strobe, done,
//                          error, write-beat accepted
//   memreq, memwe, memaddr, memsz, memlen, memwdata   bus request side
//   memack, memrdata, memerr                          bus response side
//
// Read data is not registered here: memrdata goes straight to both caches and
// icvalid/dcvalid tell each one when a beat belongs to it.
// -----------------------------------------------------------------------------
module mem_arb #(
  parameter int BEATS = 4,
  parameter int TMO   = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  // I-side
  input  logic        icreq,
  input  logic [31:0] icaddr,
  output logic        icgnt,
  output logic        icvalid,
  output logic        icdone,
  output logic        icerr,
  // D-side
  input  logic        dcreq,
  input  logic        dcwe,
  input  logic        dcburst,
  input  logic [31:0] dcaddr,
  input  logic [2:0]  dcsz,
  input  logic [63:0] dcwdata,
  output logic        dcgnt,
  output logic        dcvalid,
  output logic        dcdone,
  output logic        dcerr,
  output logic        dcwack,
  // memory bus
  output logic        memreq,
  output logic        memwe,
  output logic [31:0] memaddr,
  output logic [2:0]  memsz,
  output logic [3:0]  memlen,
  output logic [63:0] memwdata,
  input  logic        memack,
  input  logic [63:0] memrdata,
  input  logic        memerr
);

  // Bursts are line aligned: clear the byte offset within a BEATS*8-byte line.
  localparam logic [31:0] LINE_MASK = ~(32'(BEATS * 8) - 32'd1);
  localparam logic [3:0]  BURST_LEN = 4'(BEATS - 1);
  localparam int          TW        = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_DR, OWN_DW} owner_e;

  state_e         state_q;
  owner_e         owner_q;
  logic           memreq_q;
  logic           memwe_q;
  logic [31:0]    memaddr_q;
  logic [2:0]     memsz_q;
  logic [3:0]     memlen_q;
  logic [3:0]     beat_q;
  logic [TW-1:0]  tmo_q;
  logic [1:0]     dstreak_q;
  logic           icgnt_q;
  logic           dcgnt_q;
  logic           icdone_q;
  logic           dcdone_q;
  logic           icerr_q;
  logic           dcerr_q;

  logic [3:0]     beat_d;
  logic [TW-1:0]  tmo_d;
  logic           pick_i;
  logic           ack_x;
  logic           last_beat;
  logic           tmo_hit;
  logic           xfer_err;
  logic           xfer_end;

  // NOTE: every signal assigned in this block is assigned on every pass, so
  // no storage is implied; a missing assignment here would infer a latch.
  always_comb begin
    // I wins when the D-side is quiet or the D streak has reached its limit.
    pick_i    = icreq && (!dcreq || dstreak_q == 2'd2);
    ack_x     = memack && (state_q == XFER);
    beat_d    = beat_q + {3'd0, memack};
    // Timeout counts consecutive ack-less XFER cycles; an ack restarts it.
    tmo_d     = memack ? '0 : tmo_q + 1'b1;
    last_beat = memack && (beat_q == memlen_q);
    tmo_hit   = (tmo_d == TW'(TMO));
    // An error in the same cycle as the final ack still reports an error.
    xfer_err  = memerr || tmo_hit;
    xfer_end  = last_beat || xfer_err;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      memreq_q  <= 1'b0;
      memwe_q   <= 1'b0;
      memaddr_q <= '0;
      memsz_q   <= '0;
      memlen_q  <= '0;
      beat_q    <= '0;
      tmo_q     <= '0;
      dstreak_q <= '0;
      icgnt_q   <= 1'b0;
      dcgnt_q   <= 1'b0;
      icdone_q  <= 1'b0;
      dcdone_q  <= 1'b0;
      icerr_q   <= 1'b0;
      dcerr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (icreq || dcreq) begin
            state_q  <= XFER;
            memreq_q <= 1'b1;
            beat_q   <= '0;
            tmo_q    <= '0;
            if (pick_i) begin
              owner_q   <= OWN_I;
              icgnt_q   <= 1'b1;
              memwe_q   <= 1'b0;
              memaddr_q <= icaddr & LINE_MASK;
              memsz_q   <= 3'd7;
              memlen_q  <= BURST_LEN;
              dstreak_q <= '0;
            end else begin
              owner_q <= dcwe ? OWN_DW : OWN_DR;
              dcgnt_q <= 1'b1;
              memwe_q <= dcwe;
              if (dcburst) begin
                memaddr_q <= dcaddr & LINE_MASK;
                memsz_q   <= 3'd7;
                memlen_q  <= BURST_LEN;
              end else begin
                memaddr_q <= dcaddr;
                memsz_q   <= dcsz;
                memlen_q  <= '0;
              end
              // Only D grants that overtake a waiting I request count.
              if (icreq && dstreak_q != 2'd3) begin
                dstreak_q <= dstreak_q + 2'd1;
              end
            end
          end
        end

        XFER: begin
          beat_q <= beat_d;
          tmo_q  <= tmo_d;
          if (xfer_end) begin
            state_q  <= DONE;
            memreq_q <= 1'b0;
            icdone_q <= (owner_q == OWN_I);
            dcdone_q <= (owner_q != OWN_I);
            icerr_q  <= xfer_err && (owner_q == OWN_I);
            dcerr_q  <= xfer_err && (owner_q != OWN_I);
          end
        end

        DONE: begin
          state_q  <= IDLE;
          icgnt_q  <= 1'b0;
          dcgnt_q  <= 1'b0;
          icdone_q <= 1'b0;
          dcdone_q <= 1'b0;
          icerr_q  <= 1'b0;
          dcerr_q  <= 1'b0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Beat strobes follow memack combinationally, but only inside XFER.
  assign icvalid  = ack_x && (owner_q == OWN_I);
  assign dcvalid  = ack_x && (owner_q == OWN_DR);
  assign dcwack   = ack_x && (owner_q == OWN_DW);

  assign icgnt    = icgnt_q;
  assign dcgnt    = dcgnt_q;
  assign icdone   = icdone_q;
  assign dcdone   = dcdone_q;
  assign icerr    = icerr_q;
  assign dcerr    = dcerr_q;

  assign memreq   = memreq_q;
  assign memwe    = memwe_q;
  assign memaddr  = memaddr_q;
  assign memsz    = memsz_q;
  assign memlen   = memlen_q;
  assign memwdata = (dcgnt_q && memwe_q) ? dcwdata : '0;

  // Read data bypasses the arbiter; it is only qualified by the valid strobes.
  logic unused_rdata;
  assign unused_rdata = ^memrdata;

endmodule

// File: tb/tb_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_arb
//
// Directed stimulus for mem_arb. Each scenario pushes the bus events it
// expects (grant, data beat, done) into a queue; a monitor samples the DUT on
// the falling edge and pops/compares whenever the DUT shows one of those
// events. Grant latency is checked as cycles since the previous done, and
// done latency as cycles since the grant.
// -----------------------------------------------------------------------------
module tb_mem_arb;

  localparam logic [1:0] K_GNT  = 2'd1;
  localparam logic [1:0] K_BEAT = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  localparam logic [1:0] W_I   = 2'd0;
  localparam logic [1:0] W_DR  = 2'd1;
  localparam logic [1:0] W_DW  = 2'd2;
  localparam logic [1:0] W_BAD = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [1:0]  who;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [3:0]  len;
    logic [63:0] data;
    logic [1:0]  err;   // {icerr, dcerr}
    int          lat;   // -1: not checked
  } ev_t;

  logic        clk;
  logic        reset_n;
  logic        icreq;
  logic [31:0] icaddr;
  logic        icgnt, icvalid, icdone, icerr;
  logic        dcreq, dcwe, dcburst;
  logic [31:0] dcaddr;
  logic [2:0]  dcsz;
  logic [63:0] dcwdata;
  logic        dcgnt, dcvalid, dcdone, dcerr, dcwack;
  logic        memreq, memwe;
  logic [31:0] memaddr;
  logic [2:0]  memsz;
  logic [3:0]  memlen;
  logic [63:0] memwdata;
  logic        memack;
  logic [63:0] memrdata;
  logic        memerr;

  ev_t exp_q[$];
  int  vectors    = 0;
  int  miscompares = 0;
  int  cyc        = 0;

  mem_arb #(.BEATS(4), .TMO(255)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .icreq    (icreq),
    .icaddr   (icaddr),
    .icgnt    (icgnt),
    .icvalid  (icvalid),
    .icdone   (icdone),
    .icerr    (icerr),
    .dcreq    (dcreq),
    .dcwe     (dcwe),
    .dcburst  (dcburst),
    .dcaddr   (dcaddr),
    .dcsz     (dcsz),
    .dcwdata  (dcwdata),
    .dcgnt    (dcgnt),
    .dcvalid  (dcvalid),
    .dcdone   (dcdone),
    .dcerr    (dcerr),
    .dcwack   (dcwack),
    .memreq   (memreq),
    .memwe    (memwe),
    .memaddr  (memaddr),
    .memsz    (memsz),
    .memlen   (memlen),
    .memwdata (memwdata),
    .memack   (memack),
    .memrdata (memrdata),
    .memerr   (memerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s act=%h exp=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ev_t mk(input logic [1:0] kind, input logic [1:0] who);
    ev_t e;
    e.kind = kind;
    e.who  = who;
    e.we   = 1'b0;
    e.addr = '0;
    e.sz   = '0;
    e.len  = '0;
    e.data = '0;
    e.err  = '0;
    e.lat  = -1;
    return e;
  endfunction

  function automatic ev_t ev_gnt(input logic [1:0] who, input logic we, input logic [31:0] addr,
                                 input logic [2:0] sz, input logic [3:0] len, input int lat);
    ev_t e;
    e      = mk(K_GNT, who);
    e.we   = we;
    e.addr = addr;
    e.sz   = sz;
    e.len  = len;
    e.lat  = lat;
    return e;
  endfunction

  function automatic ev_t ev_beat(input logic [1:0] who, input logic [63:0] data);
    ev_t e;
    e      = mk(K_BEAT, who);
    e.data = data;
    return e;
  endfunction

  function automatic ev_t ev_done(input logic [1:0] who, input logic err, input int lat);
    ev_t e;
    e     = mk(K_DONE, who);
    e.err = (who == W_I) ? {err, 1'b0} : {1'b0, err};
    e.lat = lat;
    return e;
  endfunction

  // Only the fields that matter for each event kind take part in the compare.
  function automatic logic [127:0] pack(input ev_t e);
    case (e.kind)
      K_GNT:   return 128'({e.kind, e.who, e.we, e.addr, e.sz, e.len});
      K_BEAT:  return 128'({e.kind, e.who, e.data});
      default: return 128'({e.kind, e.who, e.err});
    endcase
  endfunction

  function automatic logic [127:0] all_outs();
    return 128'({icgnt, icvalid, icdone, icerr, dcgnt, dcvalid, dcdone, dcerr, dcwack,
                 memreq, memwe, memaddr, memsz, memlen, memwdata});
  endfunction

  task automatic observe(input string name, input ev_t act);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_%s act=%h exp=none (t=%0t)", name, pack(act), $time);
    end else begin
      e = exp_q.pop_front();
      check(name, pack(act), pack(e));
      if (e.lat >= 0) check({name, "_lat"}, 128'(act.lat), 128'(e.lat));
    end
  endtask

  task automatic push_beats(input logic [1:0] who, input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) exp_q.push_back(ev_beat(who, base + 64'(i)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input string name);
    int n;
    n = 0;
    while (!memreq && n < 50) begin
      tick();
      n++;
    end
    check({name, "_gnt_seen"}, 128'(memreq), 128'(1));
  endtask

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    while (!(icdone || dcdone) && n < bound) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, 128'(icdone || dcdone), 128'(1));
  endtask

  task automatic ack_beats(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      memack   = 1'b1;
      memrdata = base + 64'(i);
      tick();
    end
    memack   = 1'b0;
    memrdata = '0;
  endtask

  task automatic drained(input string name);
    check({name, "_drained"}, 128'(exp_q.size()), 128'(0));
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin
    logic prev_req;
    int   gnt_cyc;
    int   done_cyc;
    ev_t  a;
    prev_req = 1'b0;
    gnt_cyc  = 0;
    done_cyc = -1000;
    forever begin
      @(negedge clk);
      if (memreq && !prev_req) begin
        a = mk(K_GNT, (icgnt && !dcgnt) ? W_I :
                      (dcgnt && !icgnt) ? (memwe ? W_DW : W_DR) : W_BAD);
        a.we   = memwe;
        a.addr = memaddr;
        a.sz   = memsz;
        a.len  = memlen;
        a.lat  = cyc - done_cyc;
        gnt_cyc = cyc;
        observe("gnt", a);
      end
      if (icvalid || dcvalid || dcwack) begin
        case ({icvalid, dcvalid, dcwack})
          3'b100:  a = mk(K_BEAT, W_I);
          3'b010:  a = mk(K_BEAT, W_DR);
          3'b001:  a = mk(K_BEAT, W_DW);
          default: a = mk(K_BEAT, W_BAD);
        endcase
        a.data = dcwack ? memwdata : memrdata;
        observe("beat", a);
      end
      if (icdone || dcdone) begin
        a = mk(K_DONE, (icdone && !dcdone) ? W_I :
                       (dcdone && !icdone) ? (memwe ? W_DW : W_DR) : W_BAD);
        a.err = {icerr, dcerr};
        a.lat = cyc - gnt_cyc;
        done_cyc = cyc;
        observe("done", a);
      end
      prev_req = memreq;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset_n  = 1'b0;
    icreq    = 1'b0;
    icaddr   = '0;
    dcreq    = 1'b0;
    dcwe     = 1'b0;
    dcburst  = 1'b0;
    dcaddr   = '0;
    dcsz     = '0;
    dcwdata  = '0;
    memack   = 1'b0;
    memrdata = '0;
    memerr   = 1'b0;

    #3;
    check("reset_outs", all_outs(), '0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // I-side burst: 0x1234 aligns to 0x1220, four beats, clean done.
    exp_q.push_back(ev_gnt(W_I, 1'b0, 32'h0000_1220, 3'd7, 4'd3, -1));
    push_beats(W_I, 4, 64'hA000_0000_0000_0000);
    exp_q.push_back(ev_done(W_I, 1'b0, 4));
    icreq   = 1'b1;
    icaddr  = 32'h0000_1234;
    dcwdata = 64'hDEAD_BEEF_0000_0001;
    wait_gnt("iburst");
    check("iburst_wdata_zero", 128'(memwdata), '0);
    ack_beats(4, 64'hA000_0000_0000_0000);
    icreq = 1'b0;
    tick();
    drained("iburst");

    // Simultaneous D-write single and I burst: D first, I after DONE + 1 IDLE.
    exp_q.push_back(ev_gnt(W_DW, 1'b1, 32'h0000_0100, 3'd3, 4'd0, -1));
    exp_q.push_back(ev_beat(W_DW, 64'h1111_2222_3333_4444));
    exp_q.push_back(ev_done(W_DW, 1'b0, 1));
    exp_q.push_back(ev_gnt(W_I, 1'b0, 32'h0000_2000, 3'd7, 4'd3, 2));
    push_beats(W_I, 4, 64'hA100_0000_0000_0000);
    exp_q.push_back(ev_done(W_I, 1'b0, 4));
    dcreq   = 1'b1;
    dcwe    = 1'b1;
    dcburst = 1'b0;
    dcsz    = 3'd3;
    dcaddr  = 32'h0000_0100;
    dcwdata = 64'h1111_2222_3333_4444;
    icreq   = 1'b1;
    icaddr  = 32'h0000_2008;
    wait_gnt("simul_d");
    ack_beats(1, 64'h0);
    dcreq = 1'b0;
    dcwe  = 1'b0;
    wait_gnt("simul_i");
    ack_beats(4, 64'hA100_0000_0000_0000);
    icreq = 1'b0;
    tick();
    drained("simul");

    // Starvation guard: I held, D keeps requesting reads -> D, D, I, D.
    exp_q.push_back(ev_gnt(W_DR, 1'b0, 32'h0000_0400, 3'd7, 4'd0, -1));
    exp_q.push_back(ev_beat(W_DR, 64'h0B00));
    exp_q.push_back(ev_done(W_DR, 1'b0, 1));
    exp_q.push_back(ev_gnt(W_DR, 1'b0, 32'h0000_0400, 3'd7, 4'd0, 2));
    exp_q.push_back(ev_beat(W_DR, 64'h0B10));
    exp_q.push_back(ev_done(W_DR, 1'b0, 1));
    exp_q.push_back(ev_gnt(W_I, 1'b0, 32'h0000_3000, 3'd7, 4'd3, 2));
    push_beats(W_I, 4, 64'h0C00);
    exp_q.push_back(ev_done(W_I, 1'b0, 4));
    exp_q.push_back(ev_gnt(W_DR, 1'b0, 32'h0000_0400, 3'd7, 4'd0, 2));
    exp_q.push_back(ev_beat(W_DR, 64'h0B30));
    exp_q.push_back(ev_done(W_DR, 1'b0, 1));
    icreq   = 1'b1;
    icaddr  = 32'h0000_3010;
    dcreq   = 1'b1;
    dcwe    = 1'b0;
    dcburst = 1'b0;
    dcsz    = 3'd7;
    dcaddr  = 32'h0000_0400;
    for (int t = 0; t < 4; t++) begin
      wait_gnt($sformatf("starve%0d", t));
      if (t == 2) ack_beats(4, 64'h0C00);
      else        ack_beats(1, 64'h0B00 + 64'(t * 16));
      if (t == 2) icreq = 1'b0;
      if (t == 3) dcreq = 1'b0;
    end
    tick();
    drained("starve");

    // Bus error on beat 2 of a D-read burst; a late ack in DONE/IDLE is ignored.
    exp_q.push_back(ev_gnt(W_DR, 1'b0, 32'h0000_5660, 3'd7, 4'd3, -1));
    exp_q.push_back(ev_beat(W_DR, 64'hE000));
    exp_q.push_back(ev_done(W_DR, 1'b1, 2));
    dcreq   = 1'b1;
    dcwe    = 1'b0;
    dcburst = 1'b1;
    dcsz    = 3'd0;
    dcaddr  = 32'h0000_5678;
    wait_gnt("berr");
    ack_beats(1, 64'hE000);
    memerr = 1'b1;
    tick();
    memerr   = 1'b0;
    dcreq    = 1'b0;
    memack   = 1'b1;
    memrdata = 64'hE0FF;
    tick();
    tick();
    memack   = 1'b0;
    memrdata = '0;
    tick();
    drained("berr");

    // Ack and error together: beat still counted and strobed, error wins.
    exp_q.push_back(ev_gnt(W_DR, 1'b0, 32'h0000_6040, 3'd7, 4'd3, -1));
    exp_q.push_back(ev_beat(W_DR, 64'hF000));
    exp_q.push_back(ev_beat(W_DR, 64'hF001));
    exp_q.push_back(ev_done(W_DR, 1'b1, 2));
    dcreq  = 1'b1;
    dcaddr = 32'h0000_6040;
    wait_gnt("ackerr");
    ack_beats(1, 64'hF000);
    memack   = 1'b1;
    memerr   = 1'b1;
    memrdata = 64'hF001;
    tick();
    memack   = 1'b0;
    memerr   = 1'b0;
    memrdata = '0;
    dcreq    = 1'b0;
    tick();
    drained("ackerr");

    // Timeout: no ack for 255 XFER cycles.
    exp_q.push_back(ev_gnt(W_I, 1'b0, 32'h0000_7000, 3'd7, 4'd3, -1));
    exp_q.push_back(ev_done(W_I, 1'b1, 255));
    icreq  = 1'b1;
    icaddr = 32'h0000_7004;
    wait_gnt("tmo");
    wait_done("tmo", 300);
    icreq = 1'b0;
    tick();
    drained("tmo");

    // Timer restart: one ack in XFER cycle 200, abort 255 cycles after it.
    exp_q.push_back(ev_gnt(W_I, 1'b0, 32'h0000_7100, 3'd7, 4'd3, -1));
    exp_q.push_back(ev_beat(W_I, 64'h7777));
    exp_q.push_back(ev_done(W_I, 1'b1, 455));
    tick();
    icreq  = 1'b1;
    icaddr = 32'h0000_7100;
    wait_gnt("tmo_rst");
    repeat (199) tick();
    ack_beats(1, 64'h7777);
    wait_done("tmo_rst", 300);
    icreq = 1'b0;
    tick();
    drained("tmo_rst");

    // Reset mid-burst: outputs drop at once, no done, fresh burst afterwards.
    exp_q.push_back(ev_gnt(W_I, 1'b0, 32'h0000_8040, 3'd7, 4'd3, -1));
    exp_q.push_back(ev_beat(W_I, 64'h8000));
    icreq   = 1'b1;
    icaddr  = 32'h0000_804C;
    dcwdata = 64'h5555_AAAA_5555_AAAA;
    wait_gnt("rst_mid");
    ack_beats(1, 64'h8000);
    memack   = 1'b1;
    memrdata = 64'h8001;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_outs", all_outs(), '0);
    memack   = 1'b0;
    memrdata = '0;
    icreq    = 1'b0;
    drained("rst_mid");
    tick();
    tick();
    check("rst_hold_outs", all_outs(), '0);
    reset_n = 1'b1;
    tick();

    exp_q.push_back(ev_gnt(W_I, 1'b0, 32'h0000_9000, 3'd7, 4'd3, -1));
    push_beats(W_I, 4, 64'h9000);
    exp_q.push_back(ev_done(W_I, 1'b0, 4));
    icreq  = 1'b1;
    icaddr = 32'h0000_9000;
    wait_gnt("post_rst");
    ack_beats(4, 64'h9000);
    icreq = 1'b0;
    tick();
    tick();
    drained("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
